// File: rtl/multi_counter.sv
// rtl/multi_counter.sv - parametrised bank of independent up/down counters
// Each channel has clear, load, enable, direction, wrap/saturate mode, terminal-count pulse and sticky overflow.
module multi_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       sat,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_bound;

    // The boundary depends on the direction requested on this edge.
    always_comb begin
      at_bound = dir[g] ? (count_q == MAX_VAL) : (count_q == '0);
    end

    always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (clr[g]) begin
        count_d = '0;
        ovf_d   = 1'b0;
      end else if (load[g]) begin
        count_d = load_val[g*WIDTH +: WIDTH];
      end else if (en[g]) begin
        if (at_bound) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!sat[g]) begin
            count_d = dir[g] ? '0 : MAX_VAL;
          end
        end else begin
          count_d = dir[g] ? count_q + 1'b1 : count_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        count_q <= '0;
        tc_q    <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        tc_q    <= tc_d;
        ovf_q   <= ovf_d;
      end
    end

    assign count[g*WIDTH +: WIDTH] = count_q;
    assign tc[g]                   = tc_q;
    assign ovf[g]                  = ovf_q;
  end

endmodule

// File: tb/tb_multi_counter.sv
// tb/tb_multi_counter.sv - randomized and directed self-checking bench for multi_counter
// Two instances (8x2 and 12x4) are compared every cycle against an arithmetic reference model.
module tb_multi_counter;

  localparam int W1 = 8;
  localparam int C1 = 2;
  localparam int W2 = 12;
  localparam int C2 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [C1-1:0]    clr1 = '0, load1 = '0, en1 = '0, dir1 = '0, sat1 = '0;
  logic [C1*W1-1:0] lv1 = '0;
  logic [C1*W1-1:0] count1;
  logic [C1-1:0]    tc1, ovf1;

  logic [C2-1:0]    clr2 = '0, load2 = '0, en2 = '0, dir2 = '0, sat2 = '0;
  logic [C2*W2-1:0] lv2 = '0;
  logic [C2*W2-1:0] count2;
  logic [C2-1:0]    tc2, ovf2;

  multi_counter #(.WIDTH(W1), .CHANNELS(C1)) dut1 (
    .clk(clk), .reset(reset), .clr(clr1), .load(load1), .load_val(lv1),
    .en(en1), .dir(dir1), .sat(sat1), .count(count1), .tc(tc1), .ovf(ovf1)
  );

  multi_counter #(.WIDTH(W2), .CHANNELS(C2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr2), .load(load2), .load_val(lv2),
    .en(en2), .dir(dir2), .sat(sat2), .count(count2), .tc(tc2), .ovf(ovf2)
  );

  int m1_cnt[C1], m1_tc[C1], m1_ovf[C1];
  int m2_cnt[C2], m2_tc[C2], m2_ovf[C2];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference rules in plain integer arithmetic modulo 2^w.
  function automatic void mstep(input int w, input bit c, input bit l, input int lv,
                                input bit e, input bit d, input bit s,
                                inout int cnt, inout int t, inout int o);
    int maxv;
    maxv = (1 << w) - 1;
    t = 0;
    if (c) begin
      cnt = 0;
      o   = 0;
    end else if (l) begin
      cnt = lv;
    end else if (e) begin
      if ((d && cnt == maxv) || (!d && cnt == 0)) begin
        t = 1;
        o = 1;
        if (!s) cnt = d ? 0 : maxv;
      end else begin
        cnt = d ? cnt + 1 : cnt - 1;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C1; i++) begin m1_cnt[i] = 0; m1_tc[i] = 0; m1_ovf[i] = 0; end
    for (int i = 0; i < C2; i++) begin m2_cnt[i] = 0; m2_tc[i] = 0; m2_ovf[i] = 0; end
  endtask

  task automatic compare_all(input string phase);
    for (int i = 0; i < C1; i++) begin
      check($sformatf("%s a.count[%0d]", phase, i), int'(count1[i*W1 +: W1]), m1_cnt[i]);
      check($sformatf("%s a.tc[%0d]", phase, i), int'(tc1[i]), m1_tc[i]);
      check($sformatf("%s a.ovf[%0d]", phase, i), int'(ovf1[i]), m1_ovf[i]);
    end
    for (int i = 0; i < C2; i++) begin
      check($sformatf("%s b.count[%0d]", phase, i), int'(count2[i*W2 +: W2]), m2_cnt[i]);
      check($sformatf("%s b.tc[%0d]", phase, i), int'(tc2[i]), m2_tc[i]);
      check($sformatf("%s b.ovf[%0d]", phase, i), int'(ovf2[i]), m2_ovf[i]);
    end
  endtask

  task automatic tick(input string phase);
    for (int i = 0; i < C1; i++)
      mstep(W1, clr1[i], load1[i], int'(lv1[i*W1 +: W1]), en1[i], dir1[i], sat1[i],
            m1_cnt[i], m1_tc[i], m1_ovf[i]);
    for (int i = 0; i < C2; i++)
      mstep(W2, clr2[i], load2[i], int'(lv2[i*W2 +: W2]), en2[i], dir2[i], sat2[i],
            m2_cnt[i], m2_tc[i], m2_ovf[i]);
    @(posedge clk);
    #1;
    compare_all(phase);
  endtask

  task automatic idle1();
    clr1 = '0; load1 = '0; en1 = '0; dir1 = '0; sat1 = '0;
  endtask

  function automatic int pick_val(input int w);
    int maxv;
    maxv = (1 << w) - 1;
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return maxv - 1;
      3: return maxv;
      default: return int'($urandom_range(0, maxv));
    endcase
  endfunction

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    reset = 1'b1;

    // Basic up count on ch0
    en1 = 2'b01; dir1 = 2'b01;
    for (int k = 0; k < 5; k++) tick("up");
    check("up5 count0", int'(count1[7:0]), 5);
    check("up5 count1", int'(count1[15:8]), 0);

    // Wrap up from FE
    idle1(); load1 = 2'b01; lv1[7:0] = 8'hFE; tick("wrap_ld");
    idle1(); en1 = 2'b01; dir1 = 2'b01;
    tick("wrap1"); check("wrap1 count", int'(count1[7:0]), 8'hFF);
    tick("wrap2"); check("wrap2 count", int'(count1[7:0]), 0);
    check("wrap2 tc", int'(tc1[0]), 1); check("wrap2 ovf", int'(ovf1[0]), 1);
    tick("wrap3"); check("wrap3 count", int'(count1[7:0]), 1);
    check("wrap3 tc", int'(tc1[0]), 0); check("wrap3 ovf", int'(ovf1[0]), 1);

    // Saturate down on ch1
    idle1(); load1 = 2'b10; lv1[15:8] = 8'h01; tick("sat_ld");
    idle1(); en1 = 2'b10; dir1 = 2'b00; sat1 = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick("satdn");
      check($sformatf("satdn%0d count", k), int'(count1[15:8]), 0);
      check($sformatf("satdn%0d tc", k), int'(tc1[1]), (k == 0) ? 0 : 1);
    end
    check("satdn ovf", int'(ovf1[1]), 1);

    // Priority clr > load > en
    idle1(); load1 = 2'b01; lv1[7:0] = 8'h10; tick("pri_ld");
    clr1 = 2'b01; load1 = 2'b01; en1 = 2'b01; dir1 = 2'b01; lv1[7:0] = 8'h55;
    tick("pri_clr");
    check("pri clr count", int'(count1[7:0]), 0); check("pri clr ovf", int'(ovf1[0]), 0);
    clr1 = 2'b00; tick("pri_ld_en");
    check("pri load count", int'(count1[7:0]), 8'h55); check("pri load tc", int'(tc1[0]), 0);

    // Async reset between edges
    idle1(); load1 = 2'b11; lv1 = {8'hFE, 8'h37}; tick("ar_ld");
    idle1(); en1 = 2'b10; dir1 = 2'b10; sat1 = 2'b10;
    tick("ar_up"); tick("ar_sat");
    check("ar pre ovf1", int'(ovf1[1]), 1);
    reset = 1'b0; model_reset();
    #1;
    compare_all("ar_now");
    check("ar count", int'(count1), 0);
    @(posedge clk); #1;
    compare_all("ar_held");
    @(negedge clk); reset = 1'b1; idle1();

    // 12x4 instance: ch2 down from 0, wrap
    en2 = 4'b0100; dir2 = 4'b0000; sat2 = 4'b0000;
    tick("b_dn");
    check("b ch2 count", int'(count2[35:24]), 12'hFFF);
    check("b tc", int'(tc2), 4'b0100);
    check("b ch0 count", int'(count2[11:0]), 0);
    en2 = '0;

    // Randomized traffic on both instances
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < C1; i++) begin
        clr1[i]  = ($urandom_range(0, 31) == 0);
        load1[i] = ($urandom_range(0, 7) == 0);
        en1[i]   = ($urandom_range(0, 3) != 0);
        dir1[i]  = $urandom_range(0, 1);
        sat1[i]  = $urandom_range(0, 1);
        lv1[i*W1 +: W1] = W1'(pick_val(W1));
      end
      for (int i = 0; i < C2; i++) begin
        clr2[i]  = ($urandom_range(0, 31) == 0);
        load2[i] = ($urandom_range(0, 7) == 0);
        en2[i]   = ($urandom_range(0, 3) != 0);
        dir2[i]  = $urandom_range(0, 1);
        sat2[i]  = $urandom_range(0, 1);
        lv2[i*W2 +: W2] = W2'(pick_val(W2));
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_counter.md
# multi_counter

Parametrised multi-channel counter bank, successor to the fixed 8-bit up-counter. It provides CHANNELS independent WIDTH-bit counters, each with enable, up/down direction, synchronous parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It sits beside the ALU as its general-purpose event/timer source and replaces per-instance hard-coded counters.

## Interface

- WIDTH, 8, bits per counter (≥2)
- CHANNELS, 2, number of independent counters (≥1)
- clk  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-low; clears all state immediately on assertion; deassertion is synchronised externally
- clr  input  CHANNELS  synchronous per-channel clear (count, tc, ovf)
- load  input  CHANNELS  synchronous per-channel parallel load
- load_val  input  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH]
- en  input  CHANNELS  per-channel count enable
- dir  input  CHANNELS  1 = count up, 0 = count down
- sat  input  CHANNELS  1 = saturate at boundary, 0 = wrap
- count  output  CHANNELS*WIDTH  registered counter values, same packing as load_val
- tc  output  CHANNELS  registered terminal-count pulse
- ovf  output  CHANNELS  sticky overflow/underflow flag

## Operation

- Channels are fully independent; no shared state apart from clk/reset.
- Per-channel priority at each rising edge: clr > load > en > hold.
  - clr=1: count←0, tc←0, ovf←0.
  - load=1: count←load_val slice, tc←0, ovf unchanged.
  - en=1: count steps by one in direction dir (see boundaries).
  - otherwise: count holds, tc←0.
- Boundary event: en=1 (no clr/load) with dir=1 and count=2^WIDTH−1, or dir=0 and count=0.
  - sat=0: count wraps (max→0 or 0→max); tc←1; ovf←1.
  - sat=1: count holds at boundary; tc←1; ovf←1.
- tc is 0 on every edge that is not a boundary event; consecutive boundary events (saturate held with en=1) give tc high continuously.
- ovf set only by boundary events; cleared only by clr or reset.
- Arithmetic is unsigned modulo 2^WIDTH; no carry between channels.
- dir and sat are sampled per edge; changing them mid-count takes effect on that edge with no extra state.

## Timing

- Reset values (asynchronous, while reset=0): count=0, tc=0, ovf=0 for every channel; all inputs ignored.
- All outputs are flop outputs; no combinational path from any input to any output.
- Latency: input change at edge k is visible on count/tc/ovf after edge k (one cycle).
- tc asserts in the same cycle the wrapped/saturated count appears and lasts exactly one cycle per boundary event.
- Reset asserted mid-operation clears all channels within the same cycle regardless of clk; first update after deassertion is on the first rising edge with reset=1.
- Simultaneous clr and load on a channel: clr wins. Simultaneous load and en: load wins, no step, no tc.

## Test plan

- Reset/basic up (WIDTH=8, CHANNELS=2): deassert reset, en=2'b01, dir=2'b01 for 5 edges -> count[7:0]=5, count[15:8]=0, tc=0, ovf=0.
- Wrap up: load ch0 with 8'hFE, then en=1, dir=1, sat=0 for 3 edges -> count 8'hFF, 8'h00 (tc[0]=1 that cycle only, ovf[0]=1), 8'h01 (tc[0]=0, ovf[0] still 1).
- Saturate down: load ch1 with 8'h01, en=1, dir=0, sat=1 for 4 edges -> count[15:8]=8'h00, 8'h00, 8'h00, 8'h00; tc[1]=0,1,1,1; ovf[1]=1 from edge 2.
- Priority: ch0 at 8'h10, assert clr, load (load_val=8'h55) and en together -> count[7:0]=0, ovf[0]=0; next edge load+en only -> 8'h55, no step.
- Async reset mid-count: ch0 at 8'h37, ch1 at 8'hFF with ovf=1; pull reset low between edges -> all count/tc/ovf 0 immediately, held 0 until reset returns high.
- Channel independence/parameters: CHANNELS=4, WIDTH=12; count ch2 down from 0 with sat=0 -> ch2=12'hFFF, tc=4'b0100, other channels unchanged.
